lp_cic_filter: RTL and testbench

Single-stage CIC low-pass filter (boxcar moving average) over the last BUFFER_DEPTH samples for two signed channels, phase (I) and quadrature (Q). It sits after the lock-in demodulator mixers and produces DC-gain-1 I/Q estimates. The delay line is a circular sample RAM addressed externally by the upstream sample index.

---
 rtl/lp_cic_filter_pkg.sv | 14 +
 rtl/lp_cic_delay_ram.sv | 24 ++
 rtl/lp_cic_filter.sv | 118 +++++++++++
 tb/tb_lp_cic_filter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lp_cic_filter_pkg.sv
// rtl/lp_cic_filter_pkg.sv - width derivation helpers for the boxcar CIC filter
package lp_cic_filter_pkg;

   // Right shift that divides the running sum by the window length.
   function automatic int cic_shift(input int depth);
      return $clog2(depth);
   endfunction

   // Accumulator width: one window of full-scale samples never overflows.
   function automatic int cic_acc_width(input int data_width, input int depth);
      return data_width + $clog2(depth);
   endfunction

endpackage

// File: rtl/lp_cic_delay_ram.sv
// rtl/lp_cic_delay_ram.sv - single-clock read-first delay-line RAM, no reset
module lp_cic_delay_ram #(
   parameter int DEPTH      = 512,
   parameter int WIDTH      = 84,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wr_data,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read the slot's previous content and overwrite it in the same cycle.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         rd_data   <= mem[addr];
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/lp_cic_filter.sv
// rtl/lp_cic_filter.sv - two-channel boxcar moving-average filter, DC gain 1
module lp_cic_filter
   import lp_cic_filter_pkg::*;
#(
   parameter int BUFFER_DEPTH = 512,
   parameter int DATA_WIDTH   = 42
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic signed [DATA_WIDTH-1:0]    phase_in,
   input  logic signed [DATA_WIDTH-1:0]    quadrature_in,
   input  logic [$clog2(BUFFER_DEPTH)-1:0] addr_in,
   input  logic                            valid_in,
   output logic signed [DATA_WIDTH-1:0]    phase_out,
   output logic signed [DATA_WIDTH-1:0]    quadrature_out,
   output logic                            valid_out
);

   localparam int SHIFT = cic_shift(BUFFER_DEPTH);
   localparam int ACC_W = cic_acc_width(DATA_WIDTH, BUFFER_DEPTH);

   logic [2*DATA_WIDTH-1:0]     old_word;
   logic signed [DATA_WIDTH-1:0] old_p;
   logic signed [DATA_WIDTH-1:0] old_q;

   // fill_count saturates at BUFFER_DEPTH, so its MSB alone marks "window full".
   logic [SHIFT:0]               fill_count;
   logic                         valid_s1;
   logic                         prime_s1;
   logic signed [DATA_WIDTH-1:0] new_p_s1;
   logic signed [DATA_WIDTH-1:0] new_q_s1;

   logic                         valid_s2;
   logic signed [ACC_W-1:0]      acc_p;
   logic signed [ACC_W-1:0]      acc_q;
   logic signed [ACC_W-1:0]      acc_p_next;
   logic signed [ACC_W-1:0]      acc_q_next;
   logic signed [ACC_W-1:0]      sub_p;
   logic signed [ACC_W-1:0]      sub_q;

   lp_cic_delay_ram #(
      .DEPTH (BUFFER_DEPTH),
      .WIDTH (2*DATA_WIDTH)
   ) u_delay_ram (
      .clk     (clk),
      .wr_en   (valid_in),
      .addr    (addr_in),
      .wr_data ({quadrature_in, phase_in}),
      .rd_data (old_word)
   );

   assign old_p = old_word[DATA_WIDTH-1:0];
   assign old_q = old_word[2*DATA_WIDTH-1:DATA_WIDTH];

   // Stage 1: capture the new sample alongside the RAM read and track priming.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_s1   <= 1'b0;
         prime_s1   <= 1'b0;
         new_p_s1   <= '0;
         new_q_s1   <= '0;
         fill_count <= '0;
      end else begin
         valid_s1 <= valid_in;
         if (valid_in) begin
            new_p_s1 <= phase_in;
            new_q_s1 <= quadrature_in;
            prime_s1 <= ~fill_count[SHIFT];
            if (!fill_count[SHIFT]) begin
               fill_count <= fill_count + {{SHIFT{1'b0}}, 1'b1};
            end
         end
      end
   end

   // Until the window has been filled once, RAM content is stale and is ignored.
   always_comb begin
      sub_p = '0;
      sub_q = '0;
      if (!prime_s1) begin
         sub_p = {{SHIFT{old_p[DATA_WIDTH-1]}}, old_p};
         sub_q = {{SHIFT{old_q[DATA_WIDTH-1]}}, old_q};
      end
      acc_p_next = acc_p + {{SHIFT{new_p_s1[DATA_WIDTH-1]}}, new_p_s1} - sub_p;
      acc_q_next = acc_q + {{SHIFT{new_q_s1[DATA_WIDTH-1]}}, new_q_s1} - sub_q;
   end

   // Stage 2: running sums advance once per accepted sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_s2 <= 1'b0;
         acc_p    <= '0;
         acc_q    <= '0;
      end else begin
         valid_s2 <= valid_s1;
         if (valid_s1) begin
            acc_p <= acc_p_next;
            acc_q <= acc_q_next;
         end
      end
   end

   // Output: taking the upper DATA_WIDTH bits is the floor-rounded divide by the window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_out      <= 1'b0;
         phase_out      <= '0;
         quadrature_out <= '0;
      end else begin
         valid_out <= valid_s2;
         if (valid_s2) begin
            phase_out      <= acc_p[SHIFT +: DATA_WIDTH];
            quadrature_out <= acc_q[SHIFT +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_lp_cic_filter.sv
// tb/tb_lp_cic_filter.sv - randomized self-checking bench against a boxcar average model
module tb_lp_cic_filter;

   localparam int DEPTH = 512;
   localparam int DW    = 42;
   localparam longint MAXV = (64'sd1 <<< (DW-1)) - 1;
   localparam longint MINV = -(64'sd1 <<< (DW-1));

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic signed [DW-1:0]  phase_in = '0;
   logic signed [DW-1:0]  quadrature_in = '0;
   logic [8:0]            addr_in = '0;
   logic                  valid_in = 1'b0;
   logic signed [DW-1:0]  phase_out;
   logic signed [DW-1:0]  quadrature_out;
   logic                  valid_out;

   lp_cic_filter #(
      .BUFFER_DEPTH (DEPTH),
      .DATA_WIDTH   (DW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .phase_in       (phase_in),
      .quadrature_in  (quadrature_in),
      .addr_in        (addr_in),
      .valid_in       (valid_in),
      .phase_out      (phase_out),
      .quadrature_out (quadrature_out),
      .valid_out      (valid_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint p;
      longint q;
      int     due;
   } exp_t;

   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   exp_t   exp_q[$];
   longint win_p[$];
   longint win_q[$];
   longint sum_p = 0;
   longint sum_q = 0;
   longint last_p = 0;
   longint last_q = 0;
   longint first_p = 0;
   longint first_q = 0;
   bit     got_first = 0;
   logic [8:0] addr_ctr = '0;

   task automatic check_eq(input string tag, input longint got, input longint expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   function automatic longint floor_div(input longint s);
      longint r;
      r = s / DEPTH;
      if ((s % DEPTH != 0) && (s < 0)) r = r - 1;
      return r;
   endfunction

   function automatic longint rand_val();
      logic [63:0] r;
      logic signed [DW-1:0] v;
      r = {$urandom, $urandom};
      v = r[DW-1:0];
      return longint'(v);
   endfunction

   // Reference: average of the most recent DEPTH accepted samples since reset.
   task automatic drive(input bit v, input longint p, input longint q);
      exp_t e;
      @(negedge clk);
      valid_in      = v;
      phase_in      = p[DW-1:0];
      quadrature_in = q[DW-1:0];
      addr_in       = addr_ctr;
      if (v) begin
         addr_ctr = addr_ctr + 9'd1;
         win_p.push_back(p);
         win_q.push_back(q);
         sum_p += p;
         sum_q += q;
         if (win_p.size() > DEPTH) begin
            sum_p -= win_p.pop_front();
            sum_q -= win_q.pop_front();
         end
         e.p   = floor_div(sum_p);
         e.q   = floor_div(sum_q);
         e.due = cyc + 3;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset    = 1'b1;
      valid_in = 1'b0;
      exp_q.delete();
      win_p.delete();
      win_q.delete();
      sum_p = 0;
      sum_q = 0;
      last_p = 0;
      last_q = 0;
      got_first = 0;
      #1;
      check_eq("rst_phase", phase_out, 0);
      check_eq("rst_quad", quadrature_out, 0);
      check_eq("rst_valid", valid_out, 0);
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: compare every cycle, #1 after the active edge.
   always @(posedge clk) begin
      exp_t e;
      bit   exp_v;
      cyc++;
      #1;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check_eq("valid_out", valid_out, exp_v);
      if (exp_v) begin
         e = exp_q.pop_front();
         check_eq("phase_out", phase_out, e.p);
         check_eq("quad_out", quadrature_out, e.q);
         last_p = e.p;
         last_q = e.q;
         if (!got_first) begin
            got_first = 1;
            first_p = phase_out;
            first_q = quadrature_out;
         end
      end else begin
         check_eq("hold_phase", phase_out, last_p);
         check_eq("hold_quad", quadrature_out, last_q);
      end
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         check_eq("missed_output", 0, 1);
         void'(exp_q.pop_front());
      end
   end

   initial begin
      // Reset held 100 ns with the clock running.
      reset = 1'b1;
      #100;
      check_eq("init_phase", phase_out, 0);
      check_eq("init_quad", quadrature_out, 0);
      check_eq("init_valid", valid_out, 0);
      do_reset(2);
      repeat (4) drive(0, 0, 0);

      // DC ramp and steady state.
      for (int i = 0; i < 4*DEPTH; i++) drive(1, 1000, -1000);
      drive(0, 0, 0);
      repeat (4) @(negedge clk);
      check_eq("ramp_first_p", first_p, 1);
      check_eq("ramp_first_q", first_q, -2);
      check_eq("dc_steady_p", last_p, 1000);
      check_eq("dc_steady_q", last_q, -1000);
      check_eq("dc_out_p", phase_out, 1000);

      // Zero input decays to exactly zero.
      for (int i = 0; i < 2*DEPTH; i++) drive(1, 0, 0);
      drive(0, 0, 0);
      repeat (4) @(negedge clk);
      check_eq("decay_p", phase_out, 0);
      check_eq("decay_q", quadrature_out, 0);

      // Gapped valid with DC.
      for (int i = 0; i < 2*DEPTH + 50; i++) begin
         drive(1, 1000, -1000);
         drive(0, 0, 0);
      end
      repeat (4) @(negedge clk);
      check_eq("gap_p", phase_out, 1000);

      // Full-scale extremes.
      for (int i = 0; i < DEPTH; i++) drive(1, MAXV, MINV);
      drive(0, 0, 0);
      repeat (4) @(negedge clk);
      check_eq("fs_p", phase_out, MAXV);
      check_eq("fs_q", quadrature_out, MINV);
      for (int i = 0; i < DEPTH; i++) drive(1, MINV, MAXV);
      drive(0, 0, 0);
      repeat (4) @(negedge clk);
      check_eq("fs2_p", phase_out, MINV);
      check_eq("fs2_q", quadrature_out, MAXV);

      // Random data with random gaps.
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 3) != 0), rand_val(), rand_val());
      end
      drive(0, 0, 0);

      // Mid-stream reset during a DC run, then restart over stale RAM.
      for (int i = 0; i < 300; i++) drive(1, 1000, -1000);
      do_reset(3);
      for (int i = 0; i < DEPTH + 20; i++) drive(1, 1000, -1000);
      drive(0, 0, 0);
      repeat (4) @(negedge clk);
      check_eq("restart_first_p", first_p, 1);
      check_eq("restart_first_q", first_q, -2);
      check_eq("restart_p", phase_out, 1000);

      repeat (10) @(negedge clk);
      check_eq("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
